// File: rtl/control_mc_pkg.sv
// control_mc_pkg
// Shared constants for the multi-cycle control unit: FSM state encoding,
// RV32I opcode/funct fields, ALU operation codes, instruction classes and
// the wb_sel / pc_sel encodings seen by the datapath.
// No ports (package).
package control_mc_pkg;

  // FSM states
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Instruction classes carried from DECODE to the end of the instruction
  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_MUL    = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JAL    = 3'd5,
    CLS_JALR   = 3'd6
  } instr_class_t;

  // Major opcodes
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // funct3 values
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  // funct7 values
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ALU operation codes shared with the ALU
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_SLTU = 3'd5;
  localparam logic [2:0] ALU_MUL  = 3'd6;

  // Write-back source select
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  // Next-PC select
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_REL   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  // Classes that write a destination register in WB
  function automatic logic class_writes_rd(input instr_class_t cls);
    logic wr;
    case (cls)
      CLS_ALU, CLS_MUL, CLS_LOAD, CLS_JAL, CLS_JALR: wr = 1'b1;
      default:                                       wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/control_mc_if.sv
// control_mc_if
// Bundle of the handshake and control signals between the multi-cycle
// control unit and the fetch / datapath side.
//   master : control unit (drives requests, strobes, decoded controls)
//   slave  : fetch + datapath (drives instr, acks, alu_result)
// Signals: instr, imem_ack, imem_req, ir_we, alu_result, dmem_ack, dmem_req,
//          mem_we, imm32, alu_op, has_imm, rf_we, wb_sel, pc_we, pc_sel, halted.
interface control_mc_if #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 3
);
  logic [31:0]         instr;
  logic                imem_ack;
  logic                imem_req;
  logic                ir_we;
  logic [XLEN-1:0]     alu_result;
  logic                dmem_ack;
  logic                dmem_req;
  logic                mem_we;
  logic [XLEN-1:0]     imm32;
  logic [ALU_OP_W-1:0] alu_op;
  logic                has_imm;
  logic                rf_we;
  logic [1:0]          wb_sel;
  logic                pc_we;
  logic [1:0]          pc_sel;
  logic                halted;

  modport master (
    input  instr, imem_ack, alu_result, dmem_ack,
    output imem_req, ir_we, dmem_req, mem_we, imm32, alu_op, has_imm,
           rf_we, wb_sel, pc_we, pc_sel, halted
  );

  modport slave (
    output instr, imem_ack, alu_result, dmem_ack,
    input  imem_req, ir_we, dmem_req, mem_we, imm32, alu_op, has_imm,
           rf_we, wb_sel, pc_we, pc_sel, halted
  );
endinterface

// File: rtl/control_mc_decode.sv
// control_decode
// Purely combinational RV32I-subset decoder (ADDI, ADD, SUB, XORI, XOR, ORI,
// OR, ANDI, AND, SLTU, MUL, LW, SW, BEQ, BNE, JAL, JALR).
// Ports:
//   instr   in  32        raw instruction
//   cls     out class     instruction class
//   is_bne  out 1         branch sense (1 = BNE, 0 = BEQ)
//   imm32   out XLEN      sign-extended immediate (I/S/B/J formats)
//   alu_op  out ALU_OP_W  ALU operation
//   has_imm out 1         ALU operand B is the immediate
//   illegal out 1         encoding outside the supported subset
module control_decode
  import control_mc_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 3
) (
  input  logic [31:0]         instr,
  output instr_class_t        cls,
  output logic                is_bne,
  output logic [XLEN-1:0]     imm32,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                has_imm,
  output logic                illegal
);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_j_s;
  logic [31:0] imm_raw_s;
  logic [2:0]  alu_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];

  assign imm_i_s = {{20{instr[31]}}, instr[31:20]};
  assign imm_s_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Field decode: class, ALU op, operand select and immediate format
  always_comb begin
    cls       = CLS_ALU;
    is_bne    = 1'b0;
    imm_raw_s = 32'd0;
    alu_s     = ALU_ADD;
    has_imm   = 1'b0;
    illegal   = 1'b0;
    case (opcode_s)
      OPC_OP_IMM: begin
        has_imm   = 1'b1;
        imm_raw_s = imm_i_s;
        case (funct3_s)
          F3_ADD:  alu_s = ALU_ADD;
          F3_XOR:  alu_s = ALU_XOR;
          F3_OR:   alu_s = ALU_OR;
          F3_AND:  alu_s = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP: begin
        case ({funct7_s, funct3_s})
          {F7_BASE, F3_ADD}:   alu_s = ALU_ADD;
          {F7_ALT, F3_ADD}:    alu_s = ALU_SUB;
          {F7_BASE, F3_XOR}:   alu_s = ALU_XOR;
          {F7_BASE, F3_OR}:    alu_s = ALU_OR;
          {F7_BASE, F3_AND}:   alu_s = ALU_AND;
          {F7_BASE, F3_SLTU}:  alu_s = ALU_SLTU;
          {F7_MULDIV, F3_ADD}: begin
            alu_s = ALU_MUL;
            cls   = CLS_MUL;
          end
          default:             illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        if (funct3_s == F3_W) begin
          cls       = CLS_LOAD;
          has_imm   = 1'b1;
          imm_raw_s = imm_i_s;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        if (funct3_s == F3_W) begin
          cls       = CLS_STORE;
          has_imm   = 1'b1;
          imm_raw_s = imm_s_s;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        cls       = CLS_BRANCH;
        alu_s     = ALU_SUB;
        imm_raw_s = imm_b_s;
        case (funct3_s)
          F3_BEQ:  is_bne = 1'b0;
          F3_BNE:  is_bne = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        cls       = CLS_JAL;
        imm_raw_s = imm_j_s;
      end
      OPC_JALR: begin
        if (funct3_s == F3_ADD) begin
          cls       = CLS_JALR;
          has_imm   = 1'b1;
          imm_raw_s = imm_i_s;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  // Immediates are already sign-extended to 32 bits; widen to XLEN by sign
  assign imm32  = XLEN'($signed(imm_raw_s));
  assign alu_op = ALU_OP_W'(alu_s);

endmodule

// File: rtl/control_mc.sv
// control_mc
// Multi-cycle control unit: FETCH -> DECODE -> EXEC -> MEM -> WB sequencing
// for an RV32I subset with fetch / data-memory req-ack handshakes, a
// multi-cycle MUL wait in EXEC and a sticky HALT on illegal encodings.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous active-high reset
//   bus  control_mc_if.master (instr/acks/alu_result in; requests, strobes,
//        decoded controls and halted out)
module control_mc
  import control_mc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ALU_OP_W   = 3,
  parameter int MUL_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  control_mc_if.master  bus
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  state_t state_r, state_s;

  // Local copy of the fetched word: instr is only valid on the ack cycle
  logic [31:0] instr_r;

  // Combinational decode of instr_r
  instr_class_t        dec_cls_s;
  logic                dec_is_bne_s;
  logic [XLEN-1:0]     dec_imm_s;
  logic [ALU_OP_W-1:0] dec_alu_op_s;
  logic                dec_has_imm_s;
  logic                dec_illegal_s;

  // Decode held from DECODE to the end of the instruction
  instr_class_t        cls_r;
  logic                is_bne_r;
  logic [XLEN-1:0]     imm32_r;
  logic [ALU_OP_W-1:0] alu_op_r;
  logic                has_imm_r;

  logic [CNT_W-1:0]    mul_cnt_r;
  logic                mul_last_s;
  logic                taken_r;

  logic imem_req_s, ir_we_s, dmem_req_s, mem_we_s;
  logic rf_we_s, pc_we_s, halted_s;
  logic [1:0] wb_sel_s, pc_sel_s;

  control_decode #(
    .XLEN     (XLEN),
    .ALU_OP_W (ALU_OP_W)
  ) u_decode (
    .instr   (instr_r),
    .cls     (dec_cls_s),
    .is_bne  (dec_is_bne_s),
    .imm32   (dec_imm_s),
    .alu_op  (dec_alu_op_s),
    .has_imm (dec_has_imm_s),
    .illegal (dec_illegal_s)
  );

  assign mul_last_s = (mul_cnt_r == CNT_W'(MUL_CYCLES - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (bus.imem_ack) state_s = ST_DECODE;
        else              state_s = ST_FETCH;
      end
      ST_DECODE: begin
        if (dec_illegal_s)              state_s = ST_HALT;
        else if (dec_cls_s == CLS_JAL)  state_s = ST_WB;
        else                            state_s = ST_EXEC;
      end
      ST_EXEC: begin
        if ((cls_r == CLS_MUL) && !mul_last_s)                 state_s = ST_EXEC;
        else if ((cls_r == CLS_LOAD) || (cls_r == CLS_STORE))  state_s = ST_MEM;
        else                                                   state_s = ST_WB;
      end
      ST_MEM: begin
        if (bus.dmem_ack) state_s = ST_WB;
        else              state_s = ST_MEM;
      end
      ST_WB:   state_s = ST_FETCH;
      ST_HALT: state_s = ST_HALT;
      default: state_s = ST_FETCH;
    endcase
  end

  // Capture the fetched instruction on the ack cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_r <= 32'd0;
    end else if ((state_r == ST_FETCH) && bus.imem_ack) begin
      instr_r <= bus.instr;
    end else begin
      instr_r <= instr_r;
    end
  end

  // Decode registers, loaded once in DECODE and held until the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_r     <= CLS_ALU;
      is_bne_r  <= 1'b0;
      imm32_r   <= '0;
      alu_op_r  <= '0;
      has_imm_r <= 1'b0;
    end else if (state_r == ST_DECODE) begin
      cls_r     <= dec_cls_s;
      is_bne_r  <= dec_is_bne_s;
      imm32_r   <= dec_imm_s;
      alu_op_r  <= dec_alu_op_s;
      has_imm_r <= dec_has_imm_s;
    end else begin
      cls_r     <= cls_r;
      is_bne_r  <= is_bne_r;
      imm32_r   <= imm32_r;
      alu_op_r  <= alu_op_r;
      has_imm_r <= has_imm_r;
    end
  end

  // MUL wait counter: counts EXEC cycles, idles at zero elsewhere
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_cnt_r <= '0;
    end else if ((state_r == ST_EXEC) && (cls_r == CLS_MUL) && !mul_last_s) begin
      mul_cnt_r <= mul_cnt_r + CNT_W'(1);
    end else begin
      mul_cnt_r <= '0;
    end
  end

  // Branch outcome sampled at the end of EXEC so WB does not depend on
  // whatever the ALU shows afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_r <= 1'b0;
    end else if (state_r == ST_DECODE) begin
      taken_r <= 1'b0;
    end else if ((state_r == ST_EXEC) && (cls_r == CLS_BRANCH)) begin
      taken_r <= is_bne_r ? (bus.alu_result != '0) : (bus.alu_result == '0);
    end else begin
      taken_r <= taken_r;
    end
  end

  // Strobes from state plus held decode; FETCH outputs are masked while rst
  // is high because the async reset parks the FSM in FETCH
  always_comb begin
    imem_req_s = 1'b0;
    ir_we_s    = 1'b0;
    dmem_req_s = 1'b0;
    mem_we_s   = 1'b0;
    rf_we_s    = 1'b0;
    wb_sel_s   = WB_ALU;
    pc_we_s    = 1'b0;
    pc_sel_s   = PC_PLUS4;
    halted_s   = 1'b0;
    case (state_r)
      ST_FETCH: begin
        imem_req_s = ~rst;
        ir_we_s    = ~rst & bus.imem_ack;
      end
      ST_MEM: begin
        dmem_req_s = 1'b1;
        mem_we_s   = (cls_r == CLS_STORE);
      end
      ST_WB: begin
        pc_we_s = 1'b1;
        rf_we_s = class_writes_rd(cls_r);
        case (cls_r)
          CLS_LOAD:          wb_sel_s = WB_MEM;
          CLS_JAL, CLS_JALR: wb_sel_s = WB_LINK;
          default:           wb_sel_s = WB_ALU;
        endcase
        if ((cls_r == CLS_JAL) || ((cls_r == CLS_BRANCH) && taken_r)) begin
          pc_sel_s = PC_REL;
        end else if (cls_r == CLS_JALR) begin
          pc_sel_s = PC_JALR;
        end else begin
          pc_sel_s = PC_PLUS4;
        end
      end
      ST_HALT: halted_s = 1'b1;
      default: halted_s = 1'b0;
    endcase
  end

  assign bus.imem_req = imem_req_s;
  assign bus.ir_we    = ir_we_s;
  assign bus.dmem_req = dmem_req_s;
  assign bus.mem_we   = mem_we_s;
  assign bus.rf_we    = rf_we_s;
  assign bus.wb_sel   = wb_sel_s;
  assign bus.pc_we    = pc_we_s;
  assign bus.pc_sel   = pc_sel_s;
  assign bus.halted   = halted_s;
  assign bus.imm32    = imm32_r;
  assign bus.alu_op   = alu_op_r;
  assign bus.has_imm  = has_imm_r;

endmodule
